// File: rtl/seq_mul_add_pkg.sv
// seq_mul_pkg: shared widths and FSM state type for the sequential
// multiply-accumulate block (P = A*B + C).
//   A_W   multiplier (quotient) width
//   B_W   multiplicand (divisor) width, also the addend width
//   P_W   product width, wide enough for the largest A*B+C
//   CNT_W width of the per-bit iteration counter
package seq_mul_pkg;

  localparam int A_W   = 9;
  localparam int B_W   = 17;
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(A_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_mul_add_if.sv
// seq_mul_add_if: operand and result handshake bundle for seq_mul_add.
// Ports carried:
//   in_valid  / in_ready   operand handshake (producer -> block)
//   a, b, c                multiplier, multiplicand, addend (unsigned)
//   out_valid / out_ready  result handshake (block -> consumer)
//   product                A*B+C, unsigned
// Modports:
//   master  the side that supplies operands and consumes the product
//   slave   the multiply-accumulate block itself
interface seq_mul_add_if
  import seq_mul_pkg::*;
  ;

  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [B_W-1:0] c;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] product;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/seq_mul_add_step.sv
// mul_step: one iteration of the shift-add multiply, purely combinational.
// Ports:
//   acc       in   P_W  running sum
//   b_sh      in   P_W  multiplicand, already shifted to the current bit weight
//   a_sh      in   A_W  remaining multiplier bits, LSB is the current bit
//   acc_nxt   out  P_W  acc + b_sh when the current multiplier bit is set
//   b_sh_nxt  out  P_W  multiplicand moved to the next bit weight
//   a_sh_nxt  out  A_W  multiplier with the consumed bit shifted out
module mul_step
  import seq_mul_pkg::*;
(
  input  logic [P_W-1:0] acc,
  input  logic [P_W-1:0] b_sh,
  input  logic [A_W-1:0] a_sh,
  output logic [P_W-1:0] acc_nxt,
  output logic [P_W-1:0] b_sh_nxt,
  output logic [A_W-1:0] a_sh_nxt
);

  // P_W = A_W + B_W, so the sum can never carry out of acc.
  assign acc_nxt  = a_sh[0] ? (acc + b_sh) : acc;
  assign b_sh_nxt = b_sh << 1;
  assign a_sh_nxt = a_sh >> 1;

endmodule

// File: rtl/seq_mul_add.sv
// seq_mul_add: iterative shift-add multiply-accumulate, product = a*b + c.
// Rebuilds Dividend = Quotient*Divisor + Remainder for the divide-check path.
// One multiplier bit is consumed per clock; there is no early exit, so every
// operation takes the same number of cycles.
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   bus    seq_mul_add_if.slave
//          in_valid/in_ready   operands accepted only in IDLE
//          a, b, c             sampled on the accepting edge only
//          out_valid/out_ready product held stable until accepted
//          product             last result, kept after the handshake
module seq_mul_add
  import seq_mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  seq_mul_add_if.slave  bus
);

  mul_state_t state;
  mul_state_t state_nxt;

  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   b_sh;
  logic [A_W-1:0]   a_sh;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   product_q;

  logic [P_W-1:0]   acc_step;
  logic [P_W-1:0]   b_step;
  logic [A_W-1:0]   a_step;

  logic             in_ready_c;
  logic             out_valid_c;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(A_W - 1));

  mul_step u_step (
    .acc      (acc),
    .b_sh     (b_sh),
    .a_sh     (a_sh),
    .acc_nxt  (acc_step),
    .b_sh_nxt (b_step),
    .a_sh_nxt (a_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs. in_ready is only high in IDLE, so
  // operands offered during RUN or DONE are simply not taken.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.product   = product_q;

  // Datapath registers. The accumulator starts at the addend so the final
  // sum already includes c. product_q is captured on the last RUN cycle so it
  // is valid the moment DONE is entered and stays put until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      b_sh      <= '0;
      a_sh      <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh <= bus.a;
            b_sh <= {{(P_W-B_W){1'b0}}, bus.b};
            acc  <= {{(P_W-B_W){1'b0}}, bus.c};
            cnt  <= '0;
          end
        end
        RUN: begin
          acc  <= acc_step;
          b_sh <= b_step;
          a_sh <= a_step;
          cnt  <= cnt + CNT_W'(1);
          if (last_bit) begin
            product_q <= acc_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
